// File: rtl/graph_sched_if.sv
// ============================================================================
// Module   : graph_sched_if
// Brief    : Requester-side and engine-side bus bundle for graph_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface graph_sched_if #(
  parameter int NUM_CH     = 4,
  parameter int ID_WIDTH   = 11,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_CH-1:0]          ch_valid;
  logic [NUM_CH*ID_WIDTH-1:0] ch_id;
  logic [NUM_CH-1:0]          ch_ready;
  logic [ID_WIDTH-1:0]        g_id;
  logic                       g_data_rdy;
  logic                       g_data_vld;
  logic [DATA_WIDTH-1:0]      g_num_edges;

  // master: requesters and engine model; slave: the scheduler
  modport master (
    output ch_valid, ch_id, g_data_vld, g_num_edges,
    input  ch_ready, g_id, g_data_rdy
  );

  modport slave (
    input  ch_valid, ch_id, g_data_vld, g_num_edges,
    output ch_ready, g_id, g_data_rdy
  );
endinterface

`default_nettype wire

// File: rtl/graph_sched.sv
// ============================================================================
// Module   : graph_sched
// Brief    : Round-robin ingress, shared FIFO, paced issue to the graph engine
//            and edge-count band check. Macro GRAPH_SCHED_TIMEOUT_EN adds a
//            result watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module graph_sched #(
  parameter int NUM_CH     = 4,
  parameter int ID_WIDTH   = 11,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ISSUE_GAP  = 6,
  parameter int WINSIZE    = 200,
  parameter int TIMEOUT    = 1024
) (
  input  wire                   clk,
  input  wire                   rst,
  graph_sched_if.slave          bus,
  input  wire  [DATA_WIDTH-1:0] thr_lo,
  input  wire  [DATA_WIDTH-1:0] thr_hi,
  output logic                  result_vld,
  output logic [DATA_WIDTH-1:0] result_edges,
  output logic                  alert,
  input  wire                   alert_clr,
  output logic                  timeout_err
);

  localparam int c_PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(WINSIZE) + 1;
  localparam int c_GAP_W = $clog2(ISSUE_GAP);

  localparam logic [c_PTR_W-1:0] c_LAST_CH = c_PTR_W'(NUM_CH - 1);
  localparam logic [c_AW:0]      c_FULL    = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_WIN     = c_CNT_W'(WINSIZE);
  localparam logic [c_GAP_W-1:0] c_GAP_END = c_GAP_W'(ISSUE_GAP - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_GAP      = 3'd2,
    S_WAIT_RES = 3'd3,
    S_REPORT   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_PTR_W-1:0]  r_ptr;
  logic [c_PTR_W-1:0]  w_idx;
  logic [c_PTR_W-1:0]  w_gnt_idx;
  logic                w_found;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [ID_WIDTH-1:0] w_push_id;
  logic [NUM_CH-1:0]   w_ready;

  logic [ID_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW:0]       r_count;

  logic [c_GAP_W-1:0]    r_gap_cnt;
  logic [c_CNT_W-1:0]    r_issue_cnt;
  logic [ID_WIDTH-1:0]   r_g_id;
  logic [DATA_WIDTH-1:0] r_edges;
  logic                  r_alert;
  logic                  w_alert_set;
  logic                  w_to_fire;

`ifdef GRAPH_SCHED_TIMEOUT_EN
  localparam int                c_TO_W   = $clog2(TIMEOUT);
  localparam logic [c_TO_W-1:0] c_TO_END = c_TO_W'(TIMEOUT - 1);
  logic [c_TO_W-1:0] r_to_cnt;
`endif

  // ------------------------------------------------------------------
  // Round-robin arbiter: first valid channel at or after the pointer
  // ------------------------------------------------------------------
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = c_PTR_W'((int'(r_ptr) + i) % NUM_CH);
      if (!w_found && bus.ch_valid[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  assign w_full    = (r_count == c_FULL);
  assign w_push    = w_found & ~w_full & ~rst;
  assign w_push_id = bus.ch_id[w_gnt_idx*ID_WIDTH +: ID_WIDTH];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ready
      assign w_ready[c] = w_push && (w_gnt_idx == c_PTR_W'(c));
    end
  endgenerate

  assign bus.ch_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_push) begin
      r_ptr <= (w_gnt_idx == c_LAST_CH) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Shared FIFO
  // ------------------------------------------------------------------
  assign w_pop = (r_state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Issue / result FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_to_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_END) begin
          w_next = (r_issue_cnt == c_WIN) ? S_WAIT_RES : S_IDLE;
        end
      end
      S_WAIT_RES: begin
        // a result arriving on the final watchdog cycle still wins
        if (bus.g_data_vld) begin
          w_next = S_REPORT;
        end
`ifdef GRAPH_SCHED_TIMEOUT_EN
        else if (r_to_cnt == c_TO_END) begin
          w_next    = S_IDLE;
          w_to_fire = 1'b1;
        end
`endif
      end
      S_REPORT: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_alert_set = (r_state == S_REPORT) &&
                       ((r_edges < thr_lo) || (r_edges > thr_hi));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt   <= '0;
      r_issue_cnt <= '0;
      r_g_id      <= '0;
      r_edges     <= '0;
      r_alert     <= 1'b0;
    end else begin
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      if (r_state == S_ISSUE) begin
        r_g_id      <= r_mem[r_rd_ptr];
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end else if ((r_state == S_REPORT) || w_to_fire) begin
        r_issue_cnt <= '0;
      end
      if ((r_state == S_WAIT_RES) && bus.g_data_vld) begin
        r_edges <= bus.g_num_edges;
      end
      r_alert <= alert_clr ? 1'b0 : (r_alert | w_alert_set);
    end
  end

`ifdef GRAPH_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT_RES) ? r_to_cnt + 1'b1 : '0;
    end
  end

  assign timeout_err = w_to_fire;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus.g_id       = r_g_id;
  assign bus.g_data_rdy = (r_state == S_ISSUE);
  assign result_vld     = (r_state == S_REPORT);
  assign result_edges   = r_edges;
  // the flag shows in the REPORT cycle itself; a same-cycle clear suppresses it
  assign alert          = r_alert | (w_alert_set & ~alert_clr);

endmodule

`default_nettype wire

// File: doc/graph_sched.md
# graph_sched

Ingress controller for the CAN-ID graph engine. It arbitrates ID messages from up to NUM_CH requesters and buffers them in a shared FIFO. It paces one-cycle `g_data_rdy` issues to the engine at a fixed minimum spacing, counts issues per window, then waits for the engine's `data_vld`/`num_edges` result and checks the edge count against a programmable band to raise `alert`.

## Interface
- `NUM_CH`, 4: number of requesting channels (≥2).
- `ID_WIDTH`, 11: message ID width.
- `DATA_WIDTH`, 8: edge-count width.
- `FIFO_DEPTH`, 8: shared FIFO entries (power of two).
- `ISSUE_GAP`, 6: minimum cycles from one `g_data_rdy` pulse to the next (≥4).
- `WINSIZE`, 200: issues per window.
- `TIMEOUT`, 1024: result watchdog limit in cycles (used only with the macro).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ch_valid`  in  NUM_CH  per-channel request.
- `ch_id`  in  NUM_CH*ID_WIDTH  channel c ID at bits [c*ID_WIDTH +: ID_WIDTH].
- `ch_ready`  out  NUM_CH  one-hot grant; a transfer occurs when `ch_valid[c] & ch_ready[c]`.
- `g_id`  out  ID_WIDTH  ID to engine.
- `g_data_rdy`  out  1  one-cycle issue strobe.
- `g_data_vld`  in  1  engine result strobe.
- `g_num_edges`  in  DATA_WIDTH  engine edge count.
- `thr_lo`, `thr_hi`  in  DATA_WIDTH each  inclusive normal band.
- `result_vld`  out  1  one-cycle pulse.
- `result_edges`  out  DATA_WIDTH  latched edge count.
- `alert`  out  1  sticky anomaly flag.
- `alert_clr`  in  1  clears `alert`.
- `timeout_err`  out  1  one-cycle pulse (macro only; otherwise tied 0).

## Operation
- Arbiter: round-robin over channels with `ch_valid` set. The pointer starts at channel 0 and advances to granted+1 after each transfer. At most one grant per cycle. `ch_ready` is all-zero when the FIFO is full. `ch_ready` depends combinationally on `ch_valid`, the pointer and FIFO full.
- FIFO: push on transfer and pop on issue may occur in the same cycle. A push to a full FIFO is impossible by construction.
- FSM states and transitions:
  - IDLE → ISSUE when FIFO is non-empty.
  - ISSUE (1 cycle): pop, load `g_id`, assert `g_data_rdy`, increment `issue_cnt`. Then → GAP.
  - GAP: count ISSUE_GAP−1 cycles. Then → WAIT_RES if `issue_cnt == WINSIZE`, else → IDLE.
  - WAIT_RES: no issues. The FIFO keeps accepting. On `g_data_vld`, latch `g_num_edges` → REPORT.
  - REPORT (1 cycle): pulse `result_vld` and clear `issue_cnt`. Set `alert` if `result_edges < thr_lo` or `result_edges > thr_hi`, with thresholds sampled this cycle. → IDLE.
- `g_id` holds its value until the next ISSUE, because the engine samples it a cycle after the strobe.
- `issue_cnt` width is `$clog2(WINSIZE)+1` and it never exceeds WINSIZE.
- `g_data_vld` outside WAIT_RES is ignored.
- `alert_clr` has priority under simultaneous clear and set: the set is lost, and `alert` reads 0 the next cycle.
- Reset at any point: FIFO emptied, pointer 0, FSM to IDLE, `issue_cnt` 0. In-flight engine work is abandoned; the engine shares `rst`.

## Timing
- Reset values: `ch_ready` = 0 while `rst` is high, `g_id` = 0, `g_data_rdy` = 0, `result_vld` = 0, `result_edges` = 0, `alert` = 0, `timeout_err` = 0.
- Latency: a transfer at cycle t into an empty FIFO with the FSM in IDLE gives `g_data_rdy` at cycle t+2 (t+1: IDLE sees non-empty, t+2: ISSUE).
- Throughput: one issue per ISSUE_GAP+1 cycles (ISSUE + ISSUE_GAP−1 GAP cycles + IDLE) while the FIFO is non-empty.
- `result_vld` asserts the cycle after `g_data_vld` is seen in WAIT_RES.
- `alert` rises in the same cycle as `result_vld`.

## Configuration
- `GRAPH_SCHED_TIMEOUT_EN` defined: WAIT_RES runs a counter from 0.
  - If it reaches TIMEOUT−1 without `g_data_vld`, pulse `timeout_err` for one cycle, clear `issue_cnt` and go to IDLE. No `result_vld` is produced.
  - A `g_data_vld` arriving in the same cycle the counter reaches TIMEOUT−1 takes priority over the timeout.
- Not defined: no counter. WAIT_RES waits indefinitely, and `timeout_err` is constant 0.

## Test plan
Bench parameters for all scenarios: NUM_CH=4, FIFO_DEPTH=4, ISSUE_GAP=4, WINSIZE=4.
- Reset mid-GAP with 3 entries queued → all outputs 0 and FIFO empty. A new ID 0x10 pushed after reset is issued 2 cycles after its transfer.
- All four channels hold valid with IDs 0x1,0x2,0x3,0x4 → grants in order ch0, ch1, ch2, ch3. `ch_ready` drops to 0 when 4 entries are queued. Issues appear in order at 5-cycle spacing.
- 4 issues, then `g_data_vld` with `g_num_edges`=3, `thr_lo`=1, `thr_hi`=5 → `result_vld` one cycle later, `result_edges`=3, `alert`=0. A 5th queued ID is not issued before `result_vld`.
- Second window with `g_num_edges`=9, `thr_hi`=5 → `alert`=1 and it holds. `alert_clr` in the same cycle as a later set → `alert` reads 0 the next cycle.
- `g_data_vld` pulsed during GAP → ignored. `issue_cnt` unaffected and no `result_vld`.
- With `GRAPH_SCHED_TIMEOUT_EN` and TIMEOUT=16, no `g_data_vld` after the 4th issue → `timeout_err` pulses on the 16th WAIT_RES cycle, then issuing resumes from IDLE.
